// File: rtl/ecc_mem_ctrl_if.sv
// Host request bus and memory bus of the SEC-DED memory stage, bundled together.
// Latency: none, wires only.
// Backpressure: host holds i_req until o_ack; controller holds o_mem_req until i_mem_ack.
interface ecc_mem_ctrl_if #(
    parameter int AW = 16
);
    // host side
    logic          i_req;
    logic          i_we;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_wdata;
    logic          o_ack;
    logic [31:0]   o_rdata;
    logic          o_err;
    // memory side
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [7:0]    o_mem_wecc;
    logic          i_mem_ack;
    logic [31:0]   i_mem_rdata;
    logic [7:0]    i_mem_recc;

    // environment view: the requesting core plus the memory it fronts
    modport master (
        output i_req, i_we, i_addr, i_wdata,
        output i_mem_ack, i_mem_rdata, i_mem_recc,
        input  o_ack, o_rdata, o_err,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wecc
    );

    // controller view
    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        input  i_mem_ack, i_mem_rdata, i_mem_recc,
        output o_ack, o_rdata, o_err,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wecc
    );
endinterface

// File: rtl/ecc_mem_ctrl.sv
// SEC-DED stage between a single-port host request bus and a 32+8 bit memory.
// Latency: write ack 1 cycle after i_mem_ack, read ack 2 cycles after (plus a scrub write if enabled).
// Backpressure: one transaction in flight; i_req is ignored until the current one is acked.
// Optional feature: define ECC_MEM_SCRUB_EN to write corrected data back after single-bit read errors.
//
// Check code: every data bit owns a distinct weight-3 column of the 8-bit check byte
// (the 32 smallest such values, ascending), check bits own the unit columns. Any single
// flip gives an odd-weight syndrome equal to one column; any double flip gives a nonzero
// even-weight syndrome, which can never match a column and is reported as uncorrectable.
module ecc_mem_ctrl #(
    parameter int AW = 16,
    parameter int CW = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ecc_mem_ctrl_if.slave       bus,
    input  logic                i_cnt_clr,
    output logic [CW-1:0]       o_corr_cnt,
    output logic [CW-1:0]       o_uncorr_cnt,
    output logic [AW-1:0]       o_err_addr
);

    localparam logic [7:0] COL [32] = '{
        8'd7,  8'd11, 8'd13, 8'd14, 8'd19, 8'd21, 8'd22, 8'd25,
        8'd26, 8'd28, 8'd35, 8'd37, 8'd38, 8'd41, 8'd42, 8'd44,
        8'd49, 8'd50, 8'd52, 8'd56, 8'd67, 8'd69, 8'd70, 8'd73,
        8'd74, 8'd76, 8'd81, 8'd82, 8'd84, 8'd88, 8'd97, 8'd98
    };

    localparam logic [CW-1:0] CNT_MAX = '1;

    // check byte = XOR of the columns of all set data bits
    function automatic logic [7:0] ecc_gen(input logic [31:0] d);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                e = e ^ COL[i];
            end
        end
        return e;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MEM   = 3'd1,
        ST_CHECK = 3'd2,
`ifdef ECC_MEM_SCRUB_EN
        ST_SCRUB = 3'd4,
`endif
        ST_RESP  = 3'd3
    } state_t;

    state_t          state_q, state_d;

    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic [7:0]      mem_wecc_q;
    logic [31:0]     rd_dat_q;
    logic [7:0]      rd_ecc_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [AW-1:0]   err_addr_q;
    logic [CW-1:0]   corr_cnt_q, corr_cnt_d;
    logic [CW-1:0]   uncorr_cnt_q, uncorr_cnt_d;

    logic [7:0]      syn;
    logic [31:0]     flip_mask;
    logic            data_hit;
    logic            chk_hit;
    logic            sec_err;
    logic            ded_err;
    logic [31:0]     corr_dat;
    logic            corr_inc;
    logic            uncorr_inc;

    // syndrome decode of the registered read word
    always_comb begin
        syn       = rd_ecc_q ^ ecc_gen(rd_dat_q);
        flip_mask = 32'h0;
        data_hit  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (syn == COL[i]) begin
                flip_mask[i] = 1'b1;
                data_hit     = 1'b1;
            end
        end
        // a lone set syndrome bit means the check byte itself took the hit
        chk_hit  = (syn != 8'h00) && ((syn & (syn - 8'd1)) == 8'h00);
        sec_err  = data_hit || chk_hit;
        ded_err  = (syn != 8'h00) && !sec_err;
        corr_dat = rd_dat_q ^ flip_mask;
    end

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (bus.i_mem_ack) begin
                    state_d = mem_we_q ? ST_RESP : ST_CHECK;
                end
            end
            ST_CHECK: begin
`ifdef ECC_MEM_SCRUB_EN
                state_d = sec_err ? ST_SCRUB : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef ECC_MEM_SCRUB_EN
            ST_SCRUB: begin
                if (bus.i_mem_ack) begin
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // request capture, read-word capture, result and scrub-write registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_wecc_q  <= 8'h00;
            rd_dat_q    <= 32'h0;
            rd_ecc_q    <= 8'h00;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        mem_we_q    <= bus.i_we;
                        mem_addr_q  <= bus.i_addr;
                        mem_wdata_q <= bus.i_wdata;
                        mem_wecc_q  <= ecc_gen(bus.i_wdata);
                    end
                end
                ST_MEM: begin
                    if (bus.i_mem_ack && !mem_we_q) begin
                        rd_dat_q <= bus.i_mem_rdata;
                        rd_ecc_q <= bus.i_mem_recc;
                    end
                end
                ST_CHECK: begin
                    // uncorrectable words are handed back raw
                    rdata_q <= ded_err ? rd_dat_q : corr_dat;
                    err_q   <= ded_err;
                    if (syn != 8'h00) begin
                        err_addr_q <= mem_addr_q;
                    end
`ifdef ECC_MEM_SCRUB_EN
                    // address is still in mem_addr_q; turn the request into a write-back
                    if (sec_err) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= corr_dat;
                        mem_wecc_q  <= ecc_gen(corr_dat);
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign corr_inc   = (state_q == ST_CHECK) && sec_err;
    assign uncorr_inc = (state_q == ST_CHECK) && ded_err;

    // saturating error counters; clear has priority over a same-cycle increment
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (i_cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (corr_inc && (corr_cnt_q != CNT_MAX)) begin
                corr_cnt_d = corr_cnt_q + CW'(1);
            end
            if (uncorr_inc && (uncorr_cnt_q != CNT_MAX)) begin
                uncorr_cnt_d = uncorr_cnt_q + CW'(1);
            end
        end
    end

    // counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.o_ack       = (state_q == ST_RESP);
    assign bus.o_rdata     = rdata_q;
    assign bus.o_err       = err_q;
`ifdef ECC_MEM_SCRUB_EN
    assign bus.o_mem_req   = (state_q == ST_MEM) || (state_q == ST_SCRUB);
`else
    assign bus.o_mem_req   = (state_q == ST_MEM);
`endif
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_wecc  = mem_wecc_q;

    assign o_corr_cnt   = corr_cnt_q;
    assign o_uncorr_cnt = uncorr_cnt_q;
    assign o_err_addr   = err_addr_q;

endmodule
